// File: rtl/mem_read_data_decoder.sv
// mem_read_data_decoder
// Load-side data path of the MEM stage. Captures a load request, waits for
// the memory read word, pulls out the addressed byte/half/word using the same
// lane mapping as the store byte-lane encoder, extends it, and hands the
// registered result to writeback with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reqValid/reqReady     load request handshake
//   reqOffset, reqSize    byte offset in word; size 0=word 1=half 2=byte 3=invalid
//   reqSigned, reqRd      sign-extend select, destination register
//   memRdata, memRvalid   memory read word and its valid strobe
//   flush                 squash the outstanding or completed load
//   loadValid             one-cycle pulse, loadData/loadRd valid
//   loadData, loadRd      aligned/extended data and its destination register
//   stall                 high while a load is outstanding
//   timeout               one-cycle pulse when MAX_WAIT cycles pass without data
//   misalign              (only with MEM_MISALIGN_TRAP_EN) one-cycle pulse when a
//                         misaligned/invalid request is trapped instead of issued
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned requests.
// Without it, such requests complete normally and return 0.

module mem_read_data_decoder #(
    parameter int MAX_WAIT = 255,
    parameter int RD_W     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic [1:0]      reqOffset,
    input  logic [1:0]      reqSize,
    input  logic            reqSigned,
    input  logic [RD_W-1:0] reqRd,
    input  logic [31:0]     memRdata,
    input  logic            memRvalid,
    input  logic            flush,
    output logic            loadValid,
    output logic [31:0]     loadData,
    output logic [RD_W-1:0] loadRd,
    output logic            stall,
    output logic            timeout
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW:0] MAXV = (CW + 1)'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DROP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      cap_off;
    logic [1:0]      cap_size;
    logic            cap_sgn;
    logic [RD_W-1:0] cap_rd;

    logic [CW:0]     cnt_nxt;
    logic [31:0]     dec;
    logic [7:0]      byte_sel;
    logic            accept;
    logic            req_bad;

    assign cnt_nxt  = {1'b0, cnt} + 1'b1;
    assign accept   = reqValid && !flush;
    assign req_bad  = (reqSize == 2'd3) || ((reqSize == 2'd1) && reqOffset[0]);

    assign reqReady  = (state == IDLE) || (state == RESP);
    assign stall     = (state == WAIT) || (state == DROP);
    // A flush in the response cycle kills the pulse even though data was captured.
    assign loadValid = (state == RESP) && !flush;

    // Lane extraction on the captured request fields. Offset 0 is the most
    // significant lane, matching the store path.
    always_comb begin
        byte_sel = 8'h00;
        case (cap_off)
            2'd0:    byte_sel = memRdata[31:24];
            2'd1:    byte_sel = memRdata[23:16];
            2'd2:    byte_sel = memRdata[15:8];
            default: byte_sel = memRdata[7:0];
        endcase
    end

    always_comb begin
        dec = 32'h0;
        case (cap_size)
            2'd0: dec = memRdata;
            2'd1: begin
                if (cap_off == 2'd0)
                    dec = {{16{cap_sgn & memRdata[31]}}, memRdata[31:16]};
                else if (cap_off == 2'd2)
                    dec = {{16{cap_sgn & memRdata[15]}}, memRdata[15:0]};
            end
            2'd2:    dec = {{24{cap_sgn & byte_sel[7]}}, byte_sel};
            default: dec = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_off  <= '0;
            cap_size <= '0;
            cap_sgn  <= 1'b0;
            cap_rd   <= '0;
            loadData <= '0;
            loadRd   <= '0;
            timeout  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else begin
            timeout <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE, RESP: begin
                    state <= IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (accept && req_bad) begin
                        misalign <= 1'b1;
                    end else
`endif
                    if (accept) begin
                        cap_off  <= reqOffset;
                        cap_size <= reqSize;
                        cap_sgn  <= reqSigned;
                        cap_rd   <= reqRd;
                        cnt      <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (memRvalid) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            loadData <= dec;
                            loadRd   <= cap_rd;
                            state    <= RESP;
                        end
                    end else if (flush) begin
                        // Memory still owes us a beat; keep stalling until it lands.
                        state <= DROP;
                    end else if (cnt_nxt == MAXV) begin
                        timeout  <= 1'b1;
                        loadData <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt_nxt[CW-1:0];
                    end
                end
                DROP: begin
                    if (memRvalid) begin
                        state <= IDLE;
                    end else if (cnt_nxt == MAXV) begin
                        timeout  <= 1'b1;
                        loadData <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt_nxt[CW-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // req_bad only steers the trap path; keep it referenced in the default build.
    logic unused_ok;
    assign unused_ok = req_bad;

endmodule

// File: tb/tb_mem_read_data_decoder.sv
// Scoreboard bench for mem_read_data_decoder (MAX_WAIT = 4). Stimulus pushes
// expected {data, rd, cycle} per load; a negedge monitor pops and compares on
// every loadValid pulse.

module tb_mem_read_data_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [1:0]  reqOffset = 2'd0;
    logic [1:0]  reqSize = 2'd0;
    logic        reqSigned = 1'b0;
    logic [4:0]  reqRd = 5'd0;
    logic [31:0] memRdata = 32'h0;
    logic        memRvalid = 1'b0;
    logic        flush = 1'b0;
    logic        loadValid;
    logic [31:0] loadData;
    logic [4:0]  loadRd;
    logic        stall;
    logic        timeout;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_read_data_decoder #(.MAX_WAIT(4), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqOffset(reqOffset), .reqSize(reqSize),
        .reqSigned(reqSigned), .reqRd(reqRd),
        .memRdata(memRdata), .memRvalid(memRvalid),
        .flush(flush),
        .loadValid(loadValid), .loadData(loadData), .loadRd(loadRd),
        .stall(stall), .timeout(timeout)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int to_seen = 0;
    int mis_seen = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        int          cy;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc_n);
        end
    endtask

    // Monitor: every loadValid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (loadValid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_loadValid got data=%h rd=%0d exp no pulse (cycle %0d)",
                             loadData, loadRd, cyc_n);
                end else begin
                    mon_e = q.pop_front();
                    chk("sb_data", loadData, mon_e.d);
                    chk("sb_rd", {27'd0, loadRd}, {27'd0, mon_e.rd});
                    chk("sb_cycle", cyc_n, mon_e.cy);
                end
            end
            if (timeout) to_seen++;
`ifdef MEM_MISALIGN_TRAP_EN
            if (misalign) mis_seen++;
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one load in the current cycle, return memRvalid k cycles later.
    // Returns positioned at the start of the response cycle.
    task automatic do_load(input logic [1:0] sz, input logic [1:0] off, input logic sg,
                           input logic [4:0] rd, input logic [31:0] mem, input int k,
                           input logic [31:0] exp_d, input bit push, input string nm);
        int st;
        exp_t e;
        st = 0;
        reqValid = 1'b1; reqSize = sz; reqOffset = off; reqSigned = sg; reqRd = rd;
        if (push) begin
            e.d = exp_d; e.rd = rd; e.cy = cyc_n + k + 1;
            q.push_back(e);
        end
        cyc();
        reqValid = 1'b0;
        for (int i = 1; i <= k; i++) begin
            memRvalid = (i == k);
            memRdata  = (i == k) ? mem : 32'h5A5A5A5A;
            @(negedge clk);
            if (stall) st++;
            cyc();
        end
        memRvalid = 1'b0;
        chk({nm, "_stall_cycles"}, st, k);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_loadValid", {31'd0, loadValid}, 32'd0);
        chk("rst_loadData", loadData, 32'h0);
        chk("rst_loadRd", {27'd0, loadRd}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // 1. byte signed, offset 1, 3-cycle memory wait
        do_load(2'd2, 2'd1, 1'b1, 5'd7, 32'h12F45678, 3, 32'hFFFFFFF4, 1, "byte_s_off1");
        cyc();

        // 2. half unsigned / word / assorted lanes
        do_load(2'd1, 2'd2, 1'b0, 5'd3, 32'hAAAA8001, 1, 32'h00008001, 1, "half_u_off2");
        cyc();
        do_load(2'd0, 2'd3, 1'b1, 5'd9, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1, "word");
        cyc();
        do_load(2'd2, 2'd0, 1'b1, 5'd10, 32'h80123456, 1, 32'hFFFFFF80, 1, "byte_s_off0");
        cyc();
        do_load(2'd1, 2'd0, 1'b1, 5'd11, 32'h92340000, 1, 32'hFFFF9234, 1, "half_s_off0");
        cyc();
        do_load(2'd2, 2'd2, 1'b1, 5'd12, 32'h00007F00, 2, 32'h0000007F, 1, "byte_s_off2");
        cyc();

        // 3. back-to-back: second request issued in the first one's RESP cycle
        do_load(2'd1, 2'd0, 1'b1, 5'd1, 32'h7FFF1234, 1, 32'h00007FFF, 1, "b2b_a");
        chk("resp_reqReady", {31'd0, reqReady}, 32'd1);
        do_load(2'd2, 2'd3, 1'b0, 5'd2, 32'h123456AB, 1, 32'h000000AB, 1, "b2b_b");
        cyc();

        // 4a. flush in WAIT, memory answers 2 cycles later
        reqValid = 1'b1; reqSize = 2'd2; reqOffset = 2'd0; reqSigned = 1'b0; reqRd = 5'd4;
        cyc();
        reqValid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_stall", {31'd0, stall}, 32'd1);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("drop_stall", {31'd0, stall}, 32'd1);
        chk("drop_reqReady", {31'd0, reqReady}, 32'd0);
        cyc();
        memRvalid = 1'b1; memRdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("drop_stall2", {31'd0, stall}, 32'd1);
        cyc();
        memRvalid = 1'b0;
        @(negedge clk);
        chk("drop_done_stall", {31'd0, stall}, 32'd0);
        chk("drop_done_reqReady", {31'd0, reqReady}, 32'd1);
        cyc();

        // 4b. flush in RESP suppresses loadValid (data still captured)
        do_load(2'd0, 2'd0, 1'b0, 5'd13, 32'hCAFEF00D, 2, 32'h0, 0, "flush_resp");
        flush = 1'b1;
        @(negedge clk);
        chk("flush_resp_loadValid", {31'd0, loadValid}, 32'd0);
        chk("flush_resp_loadData", loadData, 32'hCAFEF00D);
        cyc();
        flush = 1'b0;
        cyc();

        // 5. timeout after 4 wait cycles
        begin
            int st;
            st = 0;
            reqValid = 1'b1; reqSize = 2'd0; reqOffset = 2'd0; reqRd = 5'd14;
            cyc();
            reqValid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (stall) st++;
                chk("to_no_early_pulse", {31'd0, timeout}, 32'd0);
                cyc();
            end
            chk("to_stall_cycles", st, 4);
            @(negedge clk);
            chk("to_pulse", {31'd0, timeout}, 32'd1);
            chk("to_stall", {31'd0, stall}, 32'd0);
            chk("to_loadData", loadData, 32'h0);
            cyc();
            @(negedge clk);
            chk("to_pulse_end", {31'd0, timeout}, 32'd0);
            cyc();
            memRvalid = 1'b1; memRdata = 32'h11111111;
            cyc();
            memRvalid = 1'b0;
            @(negedge clk);
            chk("stray_stall", {31'd0, stall}, 32'd0);
            chk("stray_loadData", loadData, 32'h0);
            cyc();
        end

        // 6a. async reset in the middle of a WAIT cycle
        do_load(2'd0, 2'd0, 1'b0, 5'd15, 32'h13572468, 1, 32'h13572468, 1, "pre_reset");
        reqValid = 1'b1; reqSize = 2'd2; reqOffset = 2'd0; reqRd = 5'd6;
        cyc();
        reqValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_loadValid", {31'd0, loadValid}, 32'd0);
        chk("arst_loadData", loadData, 32'h0);
        chk("arst_loadRd", {27'd0, loadRd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        cyc();

        // 6b. misaligned half at offset 1, and invalid size
`ifdef MEM_MISALIGN_TRAP_EN
        reqValid = 1'b1; reqSize = 2'd1; reqOffset = 2'd1; reqSigned = 1'b1; reqRd = 5'd5;
        cyc();
        reqValid = 1'b0;
        @(negedge clk);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        cyc();
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        cyc();
        reqValid = 1'b1; reqSize = 2'd3; reqOffset = 2'd0; reqRd = 5'd8;
        cyc();
        reqValid = 1'b0;
        @(negedge clk);
        chk("mis_size3_pulse", {31'd0, misalign}, 32'd1);
        cyc();
        cyc();
        chk("mis_count", mis_seen, 2);
`else
        do_load(2'd1, 2'd1, 1'b1, 5'd5, 32'hFFFFFFFF, 1, 32'h0, 1, "misalign_half");
        do_load(2'd3, 2'd0, 1'b1, 5'd8, 32'hFFFFFFFF, 2, 32'h0, 1, "size3");
        cyc();
`endif

        cyc();
        cyc();
        chk("sb_pending", q.size(), 0);
        chk("timeout_count", to_seen, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
